// File: rtl/ni_miter_pipe_if.sv
// rtl/ni_miter_pipe_if.sv - stimulus and observation bundle for the noninterference miter
//
// Purpose: groups the shared stimulus (valid, public and secret inputs for both
// copies) and the observation outputs of ni_miter_pipe into one bundle.
// Ports (all inside the bundle):
//   valid      advance both copies this cycle
//   pub_a/b    public inputs of copy A / copy B
//   sec_a/b    secret inputs of copy A / copy B
//   obs_a/b    last pipeline stage of copy A / copy B
//   assume_ok  public inputs matched on every valid cycle since reset
//   violation  sticky noninterference violation
//   viol_step  step count captured at the first violation
//   step_cnt   saturating count of valid cycles since reset
// master drives the stimulus, slave is the miter itself.

interface ni_miter_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             valid;
  logic [WIDTH-1:0] pub_a;
  logic [WIDTH-1:0] pub_b;
  logic [WIDTH-1:0] sec_a;
  logic [WIDTH-1:0] sec_b;
  logic [WIDTH-1:0] obs_a;
  logic [WIDTH-1:0] obs_b;
  logic             assume_ok;
  logic             violation;
  logic [CNT_W-1:0] viol_step;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output valid, pub_a, pub_b, sec_a, sec_b,
    input  obs_a, obs_b, assume_ok, violation, viol_step, step_cnt
  );

  modport slave (
    input  valid, pub_a, pub_b, sec_a, sec_b,
    output obs_a, obs_b, assume_ok, violation, viol_step, step_cnt
  );
endinterface

// File: rtl/ni_miter_pipe.sv
// rtl/ni_miter_pipe.sv - two-copy accumulate/pipeline noninterference miter
//
// Purpose: runs two identical accumulate-and-pipeline datapaths side by side on
// shared valid, per-copy public and secret inputs, tracks whether the public
// inputs stayed equal, and latches the first observable divergence seen while
// they did.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      ni_miter_pipe_if.slave (stimulus in, observations out)
// Parameters:
//   WIDTH  datapath width, DEPTH  observable pipeline stages,
//   LEAK   nonzero mixes the secret into pipeline stage 0,
//   CNT_W  width of step counter and violation timestamp.

module ni_miter_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int LEAK  = 0,
  parameter int CNT_W = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  ni_miter_pipe_if.slave bus
);

  localparam bit LEAK_EN = (LEAK != 0);

  // Index 0 is copy A, index 1 is copy B.
  logic [WIDTH-1:0] pub      [2];
  logic [WIDTH-1:0] sec_mix  [2];
  logic [WIDTH-1:0] acc_next [2];
  logic [WIDTH-1:0] acc_q    [2];
  logic [WIDTH-1:0] pipe_q   [2][DEPTH];

  logic             assume_ok_q;
  logic             violation_q;
  logic [CNT_W-1:0] viol_step_q;
  logic [CNT_W-1:0] step_cnt_q;

  logic             pub_equal;
  logic             obs_differ;
  logic             step_sat;

  assign pub[0] = bus.pub_a;
  assign pub[1] = bus.pub_b;

  // Without leakage the secret is masked off entirely, so both copies see
  // exactly the same function of their public inputs.
  assign sec_mix[0] = LEAK_EN ? bus.sec_a : '0;
  assign sec_mix[1] = LEAK_EN ? bus.sec_b : '0;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      acc_next[c] = acc_q[c] + pub[c];
    end
  end

  // Datapath copies: accumulator feeding a DEPTH-stage shift pipeline.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          pipe_q[c][i] <= '0;
        end
      end
    end else if (bus.valid) begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c]     <= acc_next[c];
        pipe_q[c][0] <= acc_next[c] ^ sec_mix[c];
        for (int i = 1; i < DEPTH; i++) begin
          pipe_q[c][i] <= pipe_q[c][i-1];
        end
      end
    end
  end

  assign pub_equal  = (bus.pub_a == bus.pub_b);
  assign obs_differ = (pipe_q[0][DEPTH-1] != pipe_q[1][DEPTH-1]);
  assign step_sat   = &step_cnt_q;

  // Monitor. The violation check deliberately uses the pre-edge assume_ok,
  // so a public mismatch arriving on the same edge as an observable mismatch
  // still records the violation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      assume_ok_q <= 1'b1;
      violation_q <= 1'b0;
      viol_step_q <= '0;
      step_cnt_q  <= '0;
    end else begin
      if (bus.valid && !step_sat) begin
        step_cnt_q <= step_cnt_q + CNT_W'(1);
      end
      if (bus.valid && !pub_equal) begin
        assume_ok_q <= 1'b0;
      end
      if (!violation_q && assume_ok_q && obs_differ) begin
        violation_q <= 1'b1;
        viol_step_q <= step_cnt_q;
      end
    end
  end

  assign bus.obs_a     = pipe_q[0][DEPTH-1];
  assign bus.obs_b     = pipe_q[1][DEPTH-1];
  assign bus.assume_ok = assume_ok_q;
  assign bus.violation = violation_q;
  assign bus.viol_step = viol_step_q;
  assign bus.step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_ni_miter_pipe.sv
// tb/tb_ni_miter_pipe.sv - directed self-checking bench for ni_miter_pipe

module tb_ni_miter_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Per-instance stimulus: 0 = LEAK=0, 1 = LEAK=1, 2 = LEAK=1 with CNT_W=3.
  logic       rst_r [3];
  logic       vld_r [3];
  logic [3:0] pa_r  [3];
  logic [3:0] pb_r  [3];
  logic [3:0] sa_r  [3];
  logic [3:0] sb_r  [3];

  ni_miter_pipe_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
  ni_miter_pipe_if #(.WIDTH(4), .CNT_W(8)) bus1 ();
  ni_miter_pipe_if #(.WIDTH(4), .CNT_W(3)) bus2 ();

  assign bus0.valid = vld_r[0];
  assign bus0.pub_a = pa_r[0];
  assign bus0.pub_b = pb_r[0];
  assign bus0.sec_a = sa_r[0];
  assign bus0.sec_b = sb_r[0];
  assign bus1.valid = vld_r[1];
  assign bus1.pub_a = pa_r[1];
  assign bus1.pub_b = pb_r[1];
  assign bus1.sec_a = sa_r[1];
  assign bus1.sec_b = sb_r[1];
  assign bus2.valid = vld_r[2];
  assign bus2.pub_a = pa_r[2];
  assign bus2.pub_b = pb_r[2];
  assign bus2.sec_a = sa_r[2];
  assign bus2.sec_b = sb_r[2];

  ni_miter_pipe #(.WIDTH(4), .DEPTH(2), .LEAK(0), .CNT_W(8)) dut0 (
    .clock(clock), .reset_n(rst_r[0]), .bus(bus0)
  );
  ni_miter_pipe #(.WIDTH(4), .DEPTH(2), .LEAK(1), .CNT_W(8)) dut1 (
    .clock(clock), .reset_n(rst_r[1]), .bus(bus1)
  );
  ni_miter_pipe #(.WIDTH(4), .DEPTH(2), .LEAK(1), .CNT_W(3)) dut2 (
    .clock(clock), .reset_n(rst_r[2]), .bus(bus2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [3:0] pa, pb, sa, sb;
    logic [3:0] eobs_a, eobs_b;
    logic       eok, eviol;
    logic [7:0] evs, estep;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  logic [3:0] e_acc, e_p0, e_p1, hold_obs;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_r[d] = 1'b0; vld_r[d] = 1'b0;
      pa_r[d] = '0; pb_r[d] = '0; sa_r[d] = '0; sb_r[d] = '0;
    end

    // LEAK=1 DEPTH=2 sequences, one edge per row, expectations hand-derived.
    //            rst  v   pa    pb    sa    sb    obs_a obs_b ok  viol vs     step
    tbl[0]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd1};
    tbl[1]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 1'b1,1'b0,8'd0, 8'd2};
    tbl[2]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1,1'b1,8'd2, 8'd3};
    tbl[3]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd3, 4'd2, 1'b1,1'b1,8'd2, 8'd4};
    tbl[4]  = '{1'b1,1'b0,4'd3, 4'd5, 4'd0, 4'd1, 4'd3, 4'd2, 1'b1,1'b1,8'd2, 8'd4};
    tbl[5]  = '{1'b1,1'b1,4'd2, 4'd2, 4'd0, 4'd0, 4'd4, 4'd5, 1'b1,1'b1,8'd2, 8'd5};
    tbl[6]  = '{1'b0,1'b1,4'd9, 4'd9, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd0};
    // simultaneous public and observable mismatch
    tbl[7]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd1};
    tbl[8]  = '{1'b1,1'b1,4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 1'b1,1'b0,8'd0, 8'd2};
    tbl[9]  = '{1'b1,1'b1,4'd2, 4'd4, 4'd0, 4'd0, 4'd2, 4'd3, 1'b0,1'b1,8'd2, 8'd3};
    tbl[10] = '{1'b0,1'b0,4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd0};
    // public mismatch first: divergence is not a violation
    tbl[11] = '{1'b1,1'b1,4'd3, 4'd5, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0,1'b0,8'd0, 8'd1};
    tbl[12] = '{1'b1,1'b1,4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd7, 1'b0,1'b0,8'd0, 8'd2};
    tbl[13] = '{1'b1,1'b1,4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd5, 1'b0,1'b0,8'd0, 8'd3};
    tbl[14] = '{1'b0,1'b1,4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd0};
    // equal secrets after reset: no violation
    tbl[15] = '{1'b1,1'b1,4'd7, 4'd7, 4'd9, 4'd9, 4'd0, 4'd0, 1'b1,1'b0,8'd0, 8'd1};
    tbl[16] = '{1'b1,1'b1,4'd7, 4'd7, 4'd9, 4'd9, 4'he, 4'he, 1'b1,1'b0,8'd0, 8'd2};
    tbl[17] = '{1'b1,1'b1,4'd7, 4'd7, 4'd9, 4'd9, 4'd7, 4'd7, 1'b1,1'b0,8'd0, 8'd3};
    tbl[18] = '{1'b1,1'b1,4'd7, 4'd7, 4'd9, 4'd9, 4'hc, 4'hc, 1'b1,1'b0,8'd0, 8'd4};
    tbl[19] = '{1'b1,1'b0,4'd1, 4'd2, 4'd3, 4'd4, 4'hc, 4'hc, 1'b1,1'b0,8'd0, 8'd4};

    // Reset all instances with valid high and junk inputs to show override.
    for (int d = 0; d < 3; d++) begin
      vld_r[d] = 1'b1; pa_r[d] = 4'd5; pb_r[d] = 4'd6; sa_r[d] = 4'd3; sb_r[d] = 4'd9;
    end
    tick();
    tick();
    chk("rst obs_a", 32'(bus0.obs_a), 32'd0);
    chk("rst obs_b", 32'(bus0.obs_b), 32'd0);
    chk("rst assume_ok", 32'(bus0.assume_ok), 32'd1);
    chk("rst violation", 32'(bus0.violation), 32'd0);
    chk("rst viol_step", 32'(bus0.viol_step), 32'd0);
    chk("rst step_cnt", 32'(bus0.step_cnt), 32'd0);
    chk("rst dut1 step_cnt", 32'(bus1.step_cnt), 32'd0);
    chk("rst dut2 assume_ok", 32'(bus2.assume_ok), 32'd1);
    for (int d = 0; d < 3; d++) begin
      vld_r[d] = 1'b0; pa_r[d] = '0; pb_r[d] = '0; sa_r[d] = '0; sb_r[d] = '0;
      rst_r[d] = 1'b1;
    end

    // LEAK=0: 100 random equal-public cycles with independent secrets.
    e_acc = '0; e_p0 = '0; e_p1 = '0;
    for (int k = 0; k < 100; k++) begin
      vld_r[0] = 1'b1;
      pa_r[0]  = 4'($urandom_range(0, 15));
      pb_r[0]  = pa_r[0];
      sa_r[0]  = 4'($urandom_range(0, 15));
      sb_r[0]  = 4'($urandom_range(0, 15));
      tick();
      e_p1  = e_p0;
      e_acc = e_acc + pa_r[0];
      e_p0  = e_acc;
      chk($sformatf("leak0 obs_a k=%0d", k), 32'(bus0.obs_a), 32'(e_p1));
      chk($sformatf("leak0 obs_b k=%0d", k), 32'(bus0.obs_b), 32'(e_p1));
    end
    chk("leak0 violation", 32'(bus0.violation), 32'd0);
    chk("leak0 assume_ok", 32'(bus0.assume_ok), 32'd1);
    chk("leak0 step_cnt", 32'(bus0.step_cnt), 32'd100);

    // Valid low for 10 cycles with mismatching public inputs.
    hold_obs = e_p1;
    vld_r[0] = 1'b0; pa_r[0] = 4'd1; pb_r[0] = 4'd2;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle obs_a k=%0d", k), 32'(bus0.obs_a), 32'(hold_obs));
      chk($sformatf("idle step k=%0d", k), 32'(bus0.step_cnt), 32'd100);
      chk($sformatf("idle ok k=%0d", k), 32'(bus0.assume_ok), 32'd1);
    end
    vld_r[0] = 1'b1; pa_r[0] = 4'd0; pb_r[0] = 4'd0;
    tick();
    chk("resume obs_a", 32'(bus0.obs_a), 32'(e_p0));
    chk("resume step_cnt", 32'(bus0.step_cnt), 32'd101);
    chk("resume assume_ok", 32'(bus0.assume_ok), 32'd1);
    vld_r[0] = 1'b0;

    // LEAK=1 table.
    for (int r = 0; r < NV; r++) begin
      rst_r[1] = tbl[r].rst_n;
      vld_r[1] = tbl[r].vld;
      pa_r[1]  = tbl[r].pa;
      pb_r[1]  = tbl[r].pb;
      sa_r[1]  = tbl[r].sa;
      sb_r[1]  = tbl[r].sb;
      tick();
      chk($sformatf("row%0d obs_a", r), 32'(bus1.obs_a), 32'(tbl[r].eobs_a));
      chk($sformatf("row%0d obs_b", r), 32'(bus1.obs_b), 32'(tbl[r].eobs_b));
      chk($sformatf("row%0d assume_ok", r), 32'(bus1.assume_ok), 32'(tbl[r].eok));
      chk($sformatf("row%0d violation", r), 32'(bus1.violation), 32'(tbl[r].eviol));
      chk($sformatf("row%0d viol_step", r), 32'(bus1.viol_step), 32'(tbl[r].evs));
      chk($sformatf("row%0d step_cnt", r), 32'(bus1.step_cnt), 32'(tbl[r].estep));
    end
    rst_r[1] = 1'b1; vld_r[1] = 1'b0;

    // CNT_W=3: saturation, leak injected at step 10.
    for (int k = 1; k <= 12; k++) begin
      vld_r[2] = 1'b1; pa_r[2] = 4'd1; pb_r[2] = 4'd1;
      sa_r[2]  = 4'd0; sb_r[2] = (k == 10) ? 4'd1 : 4'd0;
      tick();
      chk($sformatf("sat step k=%0d", k), 32'(bus2.step_cnt), (k > 7) ? 32'd7 : 32'(k));
      if (k == 11) begin
        chk("sat obs_a k=11", 32'(bus2.obs_a), 32'd10);
        chk("sat obs_b k=11", 32'(bus2.obs_b), 32'd11);
        chk("sat violation k=11", 32'(bus2.violation), 32'd0);
      end
      if (k == 12) begin
        chk("sat violation k=12", 32'(bus2.violation), 32'd1);
        chk("sat viol_step k=12", 32'(bus2.viol_step), 32'd7);
      end
    end
    vld_r[2] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_miter_pipe.md
# ni_miter_pipe

Parametrised noninterference miter for the security-verification benchmark set. It holds two identical copies of a small accumulate-and-pipeline datapath, driven by the same public stimulus and independent secret stimulus. It also monitors whether the public inputs stay equal and raises a sticky violation when the observable outputs diverge under equal public inputs. It generalises our fixed-width, single-stage noninterference benchmark in three ways: configurable width and depth, a selectable leak mode, and step counting and violation timestamping for bounded model checking.

## Interface
- WIDTH, 4, datapath width of each copy (>=1)
- DEPTH, 2, observable pipeline stages per copy (>=1)
- LEAK, 0, 0 = secret never reaches state; 1 = secret XORed into pipeline stage 0
- CNT_W, 8, width of step counter and violation timestamp (>=1)
- clock  input  1  rising-edge clock, the only clock
- reset_n  input  1  synchronous, active-low reset
- valid  input  1  advance both copies this cycle
- pub_a  input  WIDTH  public input, copy A
- pub_b  input  WIDTH  public input, copy B
- sec_a  input  WIDTH  secret input, copy A
- sec_b  input  WIDTH  secret input, copy B
- obs_a  output  WIDTH  observable output of copy A (last pipeline stage)
- obs_b  output  WIDTH  observable output of copy B
- assume_ok  output  1  public inputs equal on every valid cycle since reset
- violation  output  1  sticky noninterference violation
- viol_step  output  CNT_W  step_cnt value captured at first violation
- step_cnt  output  CNT_W  number of valid cycles since reset, saturating

## Operation
- Reset (reset_n=0 at a rising edge) forces the following values: all acc and pipe registers 0, obs_a=obs_b=0, assume_ok=1, violation=0, viol_step=0, step_cnt=0. Reset overrides all other activity, including mid-run.
- Per copy X in {a,b}, at each edge with valid=1:
  - acc_next = (acc + pub_X) mod 2^WIDTH
  - acc <= acc_next
  - pipe[0] <= acc_next ^ (LEAK ? sec_X : 0)
  - pipe[i] <= pipe[i-1] for 1 <= i < DEPTH
  - obs_X = pipe[DEPTH-1]
- With valid=0, all acc and pipe registers hold their values.
- step_cnt increments on each valid edge and saturates at 2^CNT_W-1.
- assume_ok is cleared on any valid edge where pub_a != pub_b. It stays 0 until reset. Public inputs are not compared on non-valid cycles.
- Violation check runs at every non-reset edge, whether or not valid is high. It uses the pre-edge registered values. If violation=0, assume_ok=1 and obs_a != obs_b, then violation <= 1 and viol_step <= step_cnt.
- Once set, violation and viol_step hold until reset. Later mismatches, or mismatches after assume_ok has dropped, do not change them.
- With LEAK=0, sec_a and sec_b are functionally unused. Under assume_ok=1, violation must never assert; this is the invariant that formal verification proves.

## Timing
- Public/secret data sampled at valid edge k appears on obs at the edge of the DEPTH-th valid step counting k as step 1. With continuous valid, latency is DEPTH-1 cycles after the edge that loads pipe[0].
- violation asserts one edge after the obs mismatch becomes visible.
- viol_step equals step_cnt as it was before that edge. With continuous valid from reset, the first leaking input at step 1 and DEPTH=2 gives viol_step=2.
- Simultaneous pub mismatch and obs mismatch on the same edge: the check uses the old assume_ok (1), so violation asserts. assume_ok clears on the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- LEAK=0, WIDTH=4, DEPTH=2; 100 valid cycles with pub_a=pub_b=random, sec_a and sec_b random and independent -> obs_a==obs_b every cycle; violation=0, assume_ok=1, step_cnt=100.
- LEAK=1, WIDTH=4, DEPTH=2; from reset, continuous valid, pub=1 on both, sec_a=0, sec_b=4'h1 -> edge 2: obs_a=1, obs_b=0; edge 3: violation=1, viol_step=2.
- LEAK=1; pub_a=3, pub_b=5 on the first valid edge, secrets differ -> assume_ok=0 after edge 1; violation remains 0 despite obs mismatch.
- Valid held low for 10 cycles mid-run -> obs, step_cnt and assume_ok unchanged; pub mismatch during those cycles does not clear assume_ok.
- reset_n pulsed low for one edge after a violation -> all outputs return to reset values on that edge; a subsequent equal-secret run gives no violation.
- CNT_W=3; 12 valid cycles -> step_cnt saturates at 7. Leak injected at step 10 -> viol_step=7.
